// File: rtl/rsa_skew_feeder.sv
// Diagonal skew feeder: lane j of each accepted vector leaves 1+d_j cycles later (d_j by latched dir).
// Latency: 1+j (N_2_S) or 1+(Y-1-j) (S_2_N) cycles per lane.
// Backpressure: none downstream; in_ready drops only in DRAIN when dir differs from the latched dir.
module rsa_skew_feeder #(
  parameter int Y      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 16
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                dir,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [Y*RSA_DW-1:0] in_data,
  output logic [Y*RSA_DW-1:0] out_data,
  output logic [Y-1:0]        new_cal_en,
  output logic [Y-1:0]        new_cal_done,
  output logic                busy
);

  localparam int CW  = (L > 1) ? $clog2(L) : 1;
  localparam int DCW = (Y > 1) ? $clog2(Y) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(L - 1);
  localparam logic [DCW-1:0] DCNT_INIT = DCW'(Y - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [DCW-1:0] dcnt, dcnt_nxt;
  logic           dir_lat, dir_lat_nxt;
  logic           rdy_st;
  logic           accept;
  logic           last_acc;

  // Stage k holds the whole vector accepted k+1 edges ago; each lane taps its own depth.
  logic [Y*RSA_DW-1:0] st_dat [Y];
  logic [Y-1:0]        st_en;
  logic [Y-1:0]        st_done;

  always_comb begin
    rdy_st = 1'b0;
    case (state)
      IDLE:    rdy_st = 1'b1;
      RUN:     rdy_st = 1'b1;
      DRAIN:   rdy_st = (dir == dir_lat);
      default: rdy_st = 1'b0;
    endcase
  end

  assign in_ready = sys_rst & rdy_st;
  assign accept   = in_valid & in_ready;
  assign last_acc = accept & (cnt == CNT_LAST);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dcnt_nxt    = dcnt;
    dir_lat_nxt = dir_lat;
    if (accept) begin
      if (state == IDLE) dir_lat_nxt = dir;
      if (last_acc) begin
        cnt_nxt   = '0;
        dcnt_nxt  = DCNT_INIT;
        state_nxt = (Y == 1) ? IDLE : DRAIN;
      end else begin
        cnt_nxt   = cnt + CW'(1);
        state_nxt = RUN;
      end
    end else if (state == DRAIN) begin
      // Y-1 drain cycles: leave as the counter reaches zero.
      dcnt_nxt = dcnt - DCW'(1);
      if (dcnt_nxt == '0) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dcnt    <= '0;
      dir_lat <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dcnt    <= dcnt_nxt;
      dir_lat <= dir_lat_nxt;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int k = 0; k < Y; k++) st_dat[k] <= '0;
      st_en   <= '0;
      st_done <= '0;
    end else begin
      st_dat[0]  <= accept ? in_data : '0;
      st_en[0]   <= accept;
      st_done[0] <= last_acc;
      for (int k = 1; k < Y; k++) begin
        st_dat[k]  <= st_dat[k-1];
        st_en[k]   <= st_en[k-1];
        st_done[k] <= st_done[k-1];
      end
    end
  end

  for (genvar j = 0; j < Y; j++) begin : g_lane
    localparam int DN = j;
    localparam int DS = Y - 1 - j;

    logic [RSA_DW-1:0] lane_q;
    logic              en_q;
    logic              done_q;

    always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
        lane_q <= '0;
        en_q   <= 1'b0;
        done_q <= 1'b0;
      end else begin
        lane_q <= dir_lat ? st_dat[DS][j*RSA_DW +: RSA_DW] : st_dat[DN][j*RSA_DW +: RSA_DW];
        en_q   <= dir_lat ? st_en[DS]   : st_en[DN];
        done_q <= dir_lat ? st_done[DS] : st_done[DN];
      end
    end

    assign out_data[j*RSA_DW +: RSA_DW] = lane_q;
    assign new_cal_en[j]                = en_q;
    assign new_cal_done[j]              = done_q;
  end

endmodule

// File: tb/tb_rsa_skew_feeder.sv
// Bench for rsa_skew_feeder: table-driven stimulus, per-lane scoreboard, reset corner sequences.
module tb_rsa_skew_feeder;

  localparam int Y  = 4;
  localparam int L  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            sys_rst;
  logic            dir;
  logic            in_valid;
  logic            in_ready;
  logic [Y*DW-1:0] in_data;
  logic [Y*DW-1:0] out_data;
  logic [Y-1:0]    new_cal_en;
  logic [Y-1:0]    new_cal_done;
  logic            busy;

  always #5 clk = ~clk;

  rsa_skew_feeder #(.Y(Y), .L(L), .RSA_DW(DW)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .dir          (dir),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_data     (out_data),
    .new_cal_en   (new_cal_en),
    .new_cal_done (new_cal_done),
    .busy         (busy)
  );

  typedef struct {
    logic            vld;
    logic            dr;
    logic [Y*DW-1:0] dat;
    logic            rdy;
    logic            bsy;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [DW-1:0] dat;
    logic        done;
  } exp_t;

  exp_t lq [Y][$];
  vec_t tbl[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   e0;
  int   m_phase, m_cnt, m_left;
  logic m_dir;
  int   first_en [Y];
  int   first_done [Y];
  int   last_done [Y];
  int   ndone [Y];
  int   busy_fall;
  logic prev_busy;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [Y*DW-1:0] mk(input logic [DW-1:0] base, input int k);
    logic [Y*DW-1:0] v;
    for (int j = 0; j < Y; j++) v[j*DW +: DW] = base | DW'(j << 8) | DW'(k);
    return v;
  endfunction

  function automatic vec_t row(input logic v, input logic d, input logic [Y*DW-1:0] x,
                               input logic r, input logic b);
    vec_t t;
    t.vld = v; t.dr = d; t.dat = x; t.rdy = r; t.bsy = b;
    return t;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_left = 0; m_dir = 1'b0;
    for (int j = 0; j < Y; j++) lq[j].delete();
  endtask

  task automatic clr_trk();
    for (int j = 0; j < Y; j++) begin
      first_en[j] = -1; first_done[j] = -1; last_done[j] = -1; ndone[j] = 0;
    end
    busy_fall = -1;
  endtask

  function automatic bit model_ready(input logic d);
    return (m_phase != 2) || (d == m_dir);
  endfunction

  task automatic model_update(input bit acc, input logic d, input logic [Y*DW-1:0] x, input int e);
    exp_t ex;
    bit   last;
    int   dl;
    if (acc) begin
      if (m_phase == 0) m_dir = d;
      last = (m_cnt == L - 1);
      for (int j = 0; j < Y; j++) begin
        dl = m_dir ? (Y - 1 - j) : j;
        ex.cyc = e + 1 + dl; ex.dat = x[j*DW +: DW]; ex.done = last;
        lq[j].push_back(ex);
      end
      if (last) begin m_cnt = 0; m_phase = 2; m_left = Y - 1; end
      else begin m_cnt++; m_phase = 1; end
    end else if (m_phase == 2) begin
      m_left--;
      if (m_left == 0) m_phase = 0;
    end
  endtask

  task automatic monitor();
    exp_t        ex;
    logic [17:0] expv;
    for (int j = 0; j < Y; j++) begin
      if (new_cal_en[j] && first_en[j] < 0) first_en[j] = cyc;
      if (new_cal_done[j]) begin
        ndone[j]++;
        if (first_done[j] < 0) first_done[j] = cyc;
        last_done[j] = cyc;
      end
      while (lq[j].size() > 0 && lq[j][0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL lane%0d missing word: expected %0h at edge %0d, never seen", j, lq[j][0].dat, lq[j][0].cyc);
        void'(lq[j].pop_front());
      end
      expv = '0;
      if (lq[j].size() > 0 && lq[j][0].cyc == cyc) begin
        ex = lq[j].pop_front();
        expv = {1'b1, ex.done, ex.dat};
      end
      chk($sformatf("lane%0d {en,done,data}", j), {new_cal_en[j], new_cal_done[j], out_data[j*DW +: DW]}, expv);
    end
  endtask

  task automatic step(input vec_t r);
    bit acc;
    in_valid = r.vld; dir = r.dr; in_data = r.dat;
    #1;
    chk("in_ready", in_ready, r.rdy);
    chk("busy", busy, r.bsy);
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
    acc = r.vld && model_ready(r.dr);
    @(posedge clk);
    cyc++;
    model_update(acc, r.dr, r.dat, cyc);
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, " out_data"}, out_data, '0);
    chk({nm, " new_cal_en"}, new_cal_en, '0);
    chk({nm, " new_cal_done"}, new_cal_done, '0);
    chk({nm, " busy"}, busy, 1'b0);
    chk({nm, " in_ready"}, in_ready, 1'b0);
  endtask

  task automatic plain_burst(input logic d, input logic [DW-1:0] base);
    tbl.delete();
    for (int k = 0; k < 4; k++) tbl.push_back(row(1'b1, d, mk(base, k), 1'b1, k != 0));
    for (int k = 0; k < 3; k++) tbl.push_back(row(1'b0, d, '0, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++) tbl.push_back(row(1'b0, d, '0, 1'b1, 1'b0));
  endtask

  initial begin
    sys_rst = 1'b0; in_valid = 1'b0; dir = 1'b0; in_data = '0;
    prev_busy = 1'b0;
    model_reset();
    clr_trk();
    #3;
    chk_zero_outputs("reset");
    @(posedge clk); @(posedge clk); @(negedge clk);
    sys_rst = 1'b1;

    // Basic N_2_S burst.
    clr_trk(); e0 = cyc + 1;
    plain_burst(1'b0, 16'h0000);
    run_tbl();
    for (int j = 0; j < Y; j++) begin
      chk($sformatf("A first_en lane%0d", j), first_en[j], e0 + 1 + j);
      chk($sformatf("A done edge lane%0d", j), first_done[j], e0 + 4 + j);
      chk($sformatf("A done count lane%0d", j), ndone[j], 1);
    end
    chk("A busy fall edge", busy_fall, e0 + 6);

    // Same burst flowing S_2_N.
    clr_trk(); e0 = cyc + 1;
    plain_burst(1'b1, 16'h1000);
    run_tbl();
    for (int j = 0; j < Y; j++)
      chk($sformatf("B first_en lane%0d", j), first_en[j], e0 + 1 + (Y - 1 - j));
    chk("B done edge lane0", first_done[0], e0 + 7);
    chk("B done edge lane3", first_done[3], e0 + 4);

    // Bubble in the middle of a burst.
    clr_trk(); e0 = cyc + 1;
    tbl.delete();
    tbl.push_back(row(1'b1, 1'b0, mk(16'h2000, 0), 1'b1, 1'b0));
    tbl.push_back(row(1'b1, 1'b0, mk(16'h2000, 1), 1'b1, 1'b1));
    tbl.push_back(row(1'b0, 1'b0, mk(16'h2000, 9), 1'b1, 1'b1));
    tbl.push_back(row(1'b1, 1'b0, mk(16'h2000, 2), 1'b1, 1'b1));
    tbl.push_back(row(1'b1, 1'b0, mk(16'h2000, 3), 1'b1, 1'b1));
    for (int k = 0; k < 3; k++) tbl.push_back(row(1'b0, 1'b0, '0, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++) tbl.push_back(row(1'b0, 1'b0, '0, 1'b1, 1'b0));
    run_tbl();
    for (int j = 0; j < Y; j++)
      chk($sformatf("C done edge lane%0d", j), first_done[j], e0 + 5 + j);

    // Back-to-back bursts in the same direction.
    clr_trk(); e0 = cyc + 1;
    tbl.delete();
    for (int k = 0; k < 8; k++) tbl.push_back(row(1'b1, 1'b0, mk(16'h3000, k), 1'b1, k != 0));
    for (int k = 0; k < 3; k++) tbl.push_back(row(1'b0, 1'b0, '0, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++) tbl.push_back(row(1'b0, 1'b0, '0, 1'b1, 1'b0));
    run_tbl();
    for (int j = 0; j < Y; j++) begin
      chk($sformatf("D done count lane%0d", j), ndone[j], 2);
      chk($sformatf("D done spacing lane%0d", j), last_done[j] - first_done[j], 4);
      chk($sformatf("D first done lane%0d", j), first_done[j], e0 + 4 + j);
    end

    // Direction change right after a burst: in_ready held low through DRAIN.
    clr_trk(); e0 = cyc + 1;
    tbl.delete();
    for (int k = 0; k < 4; k++) tbl.push_back(row(1'b1, 1'b0, mk(16'h4000, k), 1'b1, k != 0));
    for (int k = 0; k < 3; k++) tbl.push_back(row(1'b1, 1'b1, mk(16'h5000, 0), 1'b0, 1'b1));
    tbl.push_back(row(1'b1, 1'b1, mk(16'h5000, 0), 1'b1, 1'b0));
    for (int k = 1; k < 4; k++) tbl.push_back(row(1'b1, 1'b1, mk(16'h5000, k), 1'b1, 1'b1));
    for (int k = 0; k < 3; k++) tbl.push_back(row(1'b0, 1'b1, '0, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++) tbl.push_back(row(1'b0, 1'b1, '0, 1'b1, 1'b0));
    run_tbl();
    for (int j = 0; j < Y; j++) begin
      chk($sformatf("E done count lane%0d", j), ndone[j], 2);
      chk($sformatf("E first done lane%0d", j), first_done[j], e0 + 4 + j);
      chk($sformatf("E second done lane%0d", j), last_done[j], e0 + 14 - j);
    end

    // Reset mid-burst after two accepts.
    tbl.delete();
    for (int k = 0; k < 2; k++) tbl.push_back(row(1'b1, 1'b0, mk(16'h6000, k), 1'b1, k != 0));
    run_tbl();
    chk("F lane0 live before reset", new_cal_en[0], 1'b1);
    #2;
    sys_rst = 1'b0;
    #1;
    chk_zero_outputs("F async reset");
    model_reset();
    prev_busy = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    chk_zero_outputs("F held reset");
    @(negedge clk);
    sys_rst = 1'b1;
    clr_trk(); e0 = cyc + 1;
    plain_burst(1'b0, 16'h7000);
    run_tbl();
    for (int j = 0; j < Y; j++) begin
      chk($sformatf("F done count lane%0d", j), ndone[j], 1);
      chk($sformatf("F done edge lane%0d", j), first_done[j], e0 + 4 + j);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
